// File: rtl/wb_arbiter_pkg.sv
// Shared register-file sizing used by the register file and the writeback arbiter.
package wb_arbiter_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int REGS_DEF  = 32;

    // Register address width for a file of 'regs' architectural registers.
    function automatic int addr_w(input int regs);
        return $clog2(regs);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for long-latency writeback results. Also exposes the
// valid bit and destination register of every slot so the arbiter can report
// pending writes without walking the pointers.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int  WIDTH  = WIDTH_DEF,
    parameter int  ADDR   = addr_w(REGS_DEF),
    parameter int  QDEPTH = 4,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [ADDR-1:0]             push_reg,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [ADDR-1:0]             head_reg,
    output logic [WIDTH-1:0]            head_data,
    output logic [CW-1:0]               count,
    output logic [QDEPTH-1:0]           ent_vld,
    output logic [QDEPTH-1:0][ADDR-1:0] ent_reg
);

    logic [QDEPTH-1:0][ADDR-1:0]  regs_q;
    logic [QDEPTH-1:0][WIDTH-1:0] data_q;
    logic [QDEPTH-1:0]            vld_q;
    logic [PW-1:0]                rd_ptr, wr_ptr;
    logic [CW-1:0]                count_q;

    // Storage, pointers and occupancy; the caller never pushes into a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q  <= '0;
            data_q  <= '0;
            vld_q   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            if (push) begin
                regs_q[wr_ptr] <= push_reg;
                data_q[wr_ptr] <= push_data;
                vld_q[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (push && !pop)
                count_q <= count_q + CW'(1);
            else if (pop && !push)
                count_q <= count_q - CW'(1);
        end
    end

    assign head_reg  = regs_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign count     = count_q;
    assign ent_vld   = vld_q;
    assign ent_reg   = regs_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the register-file write port, merging the in-order
// pipeline (top priority, no back-pressure) with buffered long-latency results.
// Reports per-read-port pending flags and a starvation stall request.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int  WIDTH        = WIDTH_DEF,
    parameter int  REGS         = REGS_DEF,
    parameter int  QDEPTH       = 4,
    parameter int  STARVE_LIMIT = 8,
    localparam int ADDR         = addr_w(REGS),
    localparam int CW           = $clog2(QDEPTH + 1),
    localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_valid,
    input  logic [ADDR-1:0]  p_reg,
    input  logic [WIDTH-1:0] p_data,
    input  logic             ll_valid,
    output logic             ll_ready,
    input  logic [ADDR-1:0]  ll_reg,
    input  logic [WIDTH-1:0] ll_data,
    output logic             regwrite,
    output logic [ADDR-1:0]  wreg,
    output logic [WIDTH-1:0] wdata,
    input  logic [ADDR-1:0]  rreg1,
    input  logic [ADDR-1:0]  rreg2,
    output logic             pend1,
    output logic             pend2,
    output logic             stall_req
);

    logic                        p_win, fifo_push, fifo_pop, fifo_empty;
    logic [ADDR-1:0]             head_reg;
    logic [WIDTH-1:0]            head_data;
    logic [CW-1:0]               count;
    logic [QDEPTH-1:0]           ent_vld;
    logic [QDEPTH-1:0][ADDR-1:0] ent_reg;
    logic [SW-1:0]               starve_q, starve_nxt;

    wb_fifo #(
        .WIDTH  (WIDTH),
        .ADDR   (ADDR),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_reg  (ll_reg),
        .push_data (ll_data),
        .pop       (fifo_pop),
        .head_reg  (head_reg),
        .head_data (head_data),
        .count     (count),
        .ent_vld   (ent_vld),
        .ent_reg   (ent_reg)
    );

    // Port arbitration and handshake; writes to $0 are dropped on both sources.
    always_comb begin
        ll_ready   = (count != CW'(QDEPTH));
        fifo_empty = (count == '0);
        p_win      = p_valid && (p_reg != '0);
        fifo_pop   = !p_win && !fifo_empty;
        fifo_push  = ll_valid && ll_ready && (ll_reg != '0);
    end

    // Registered write port; address/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite <= 1'b0;
            wreg     <= '0;
            wdata    <= '0;
        end else if (p_win) begin
            regwrite <= 1'b1;
            wreg     <= p_reg;
            wdata    <= p_data;
        end else if (fifo_pop) begin
            regwrite <= 1'b1;
            wreg     <= head_reg;
            wdata    <= head_data;
        end else begin
            regwrite <= 1'b0;
        end
    end

    // Starvation count: cycles the queue head has lost the port, saturating.
    always_comb begin
        starve_nxt = starve_q;
        if (fifo_empty || fifo_pop)
            starve_nxt = '0;
        else if (p_win && starve_q != SW'(STARVE_LIMIT))
            starve_nxt = starve_q + SW'(1);
    end

    // Starvation state and its registered stall request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q  <= '0;
            stall_req <= 1'b0;
        end else begin
            starve_q  <= starve_nxt;
            stall_req <= (starve_nxt == SW'(STARVE_LIMIT));
        end
    end

    // Pending flags: queued entries plus the write currently on the port.
    always_comb begin
        pend1 = regwrite && (wreg == rreg1);
        pend2 = regwrite && (wreg == rreg2);
        for (int i = 0; i < QDEPTH; i++) begin
            if (ent_vld[i] && ent_reg[i] == rreg1) pend1 = 1'b1;
            if (ent_vld[i] && ent_reg[i] == rreg2) pend2 = 1'b1;
        end
        if (rreg1 == '0) pend1 = 1'b0;
        if (rreg2 == '0) pend2 = 1'b0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed table, hand-written multi-cycle
// sequences and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

    localparam int W   = 32;
    localparam int R   = 32;
    localparam int A   = 5;
    localparam int QD  = 4;
    localparam int LIM = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         p_valid, ll_valid, ll_ready, regwrite, pend1, pend2, stall_req;
    logic [A-1:0] p_reg, ll_reg, wreg, rreg1, rreg2;
    logic [W-1:0] p_data, ll_data, wdata;

    wb_arbiter #(.WIDTH(W), .REGS(R), .QDEPTH(QD), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_reg(p_reg), .p_data(p_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_reg(ll_reg), .ll_data(ll_data),
        .regwrite(regwrite), .wreg(wreg), .wdata(wdata),
        .rreg1(rreg1), .rreg2(rreg2), .pend1(pend1), .pend2(pend2),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct { logic [A-1:0] r; logic [W-1:0] d; } ent_t;
    ent_t         mq[$];
    logic         m_rw;
    logic [A-1:0] m_wreg;
    logic [W-1:0] m_wdata;
    int           m_starve;
    logic         m_stall;

    int ntot  = 0;
    int npass = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    function automatic logic mpend(input logic [A-1:0] r);
        if (r == 0) return 1'b0;
        if (m_rw && m_wreg == r) return 1'b1;
        foreach (mq[i]) if (mq[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rw = 1'b0; m_wreg = '0; m_wdata = '0; m_starve = 0; m_stall = 1'b0;
    endtask

    task automatic model_step();
        bit   pw, rdy, pp;
        ent_t e;
        pw  = p_valid && p_reg != 0;
        rdy = mq.size() != QD;
        pp  = !pw && mq.size() != 0;
        if (mq.size() == 0 || pp) m_starve = 0;
        else if (pw && m_starve < LIM) m_starve++;
        if (pw) begin
            m_rw = 1'b1; m_wreg = p_reg; m_wdata = p_data;
        end else if (pp) begin
            e = mq.pop_front();
            m_rw = 1'b1; m_wreg = e.r; m_wdata = e.d;
        end else begin
            m_rw = 1'b0;
        end
        if (ll_valid && rdy && ll_reg != 0) begin
            e.r = ll_reg; e.d = ll_data;
            mq.push_back(e);
        end
        m_stall = (m_starve == LIM);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".regwrite"},  32'(regwrite),  32'(m_rw));
        chk({tag, ".wreg"},      32'(wreg),      32'(m_wreg));
        chk({tag, ".wdata"},     wdata,          m_wdata);
        chk({tag, ".ll_ready"},  32'(ll_ready),  32'(mq.size() != QD));
        chk({tag, ".stall_req"}, 32'(stall_req), 32'(m_stall));
        chk({tag, ".pend1"},     32'(pend1),     32'(mpend(rreg1)));
        chk({tag, ".pend2"},     32'(pend2),     32'(mpend(rreg2)));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        p_valid = 1'b0; p_reg = '0; p_data = '0;
        ll_valid = 1'b0; ll_reg = '0; ll_data = '0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic pv; logic [A-1:0] pr; logic [W-1:0] pd;
        logic lv; logic [A-1:0] lr; logic [W-1:0] ld;
        logic [A-1:0] rr1;
        logic e_rw; logic [A-1:0] e_wreg; logic [W-1:0] e_wdata; logic e_rdy; logic e_p1;
    } vec_t;

    function automatic vec_t mk(input int pv, input int pr, input logic [W-1:0] pd,
                                input int lv, input int lr, input logic [W-1:0] ld,
                                input int rr1, input int erw, input int ewreg,
                                input logic [W-1:0] ewd, input int erdy, input int ep1);
        vec_t v;
        v.pv = 1'(pv); v.pr = A'(pr); v.pd = pd;
        v.lv = 1'(lv); v.lr = A'(lr); v.ld = ld;
        v.rr1 = A'(rr1);
        v.e_rw = 1'(erw); v.e_wreg = A'(ewreg); v.e_wdata = ewd;
        v.e_rdy = 1'(erdy); v.e_p1 = 1'(ep1);
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        int k;
        bit xfer;

        // pipeline only: 1-cycle latency, pend only during the write cycle
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,          5, 1, 5, 32'hDEADBEEF, 1, 1);
        tbl[1]  = mk(0, 0, 0,            0, 0, 0,          5, 0, 5, 32'hDEADBEEF, 1, 0);
        // long-latency only: queued (pend), written next edge, then clear
        tbl[2]  = mk(0, 0, 0,            1, 7, 32'h12345678, 7, 0, 5, 32'hDEADBEEF, 1, 1);
        tbl[3]  = mk(0, 0, 0,            0, 0, 0,          7, 1, 7, 32'h12345678, 1, 1);
        tbl[4]  = mk(0, 0, 0,            0, 0, 0,          7, 0, 7, 32'h12345678, 1, 0);
        // register $0 on both sources
        tbl[5]  = mk(1, 0, 32'h1111,     0, 0, 0,          0, 0, 7, 32'h12345678, 1, 0);
        tbl[6]  = mk(0, 0, 0,            1, 0, 32'h2222,   0, 0, 7, 32'h12345678, 1, 0);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,          0, 0, 7, 32'h12345678, 1, 0);
        // same-cycle conflict on reg 3: pipeline first, queued value next
        tbl[8]  = mk(1, 3, 32'hAAAA,     1, 3, 32'hBBBB,   3, 1, 3, 32'hAAAA, 1, 1);
        tbl[9]  = mk(0, 0, 0,            0, 0, 0,          3, 1, 3, 32'hBBBB, 1, 1);
        tbl[10] = mk(0, 0, 0,            0, 0, 0,          3, 0, 3, 32'hBBBB, 1, 0);

        // reset state
        reset = 1'b1; idle(); rreg1 = '0; rreg2 = '0;
        model_reset();
        #1;
        chk("rst.regwrite",  32'(regwrite),  0);
        chk("rst.wreg",      32'(wreg),      0);
        chk("rst.wdata",     wdata,          0);
        chk("rst.ll_ready",  32'(ll_ready),  1);
        chk("rst.stall_req", 32'(stall_req), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        rreg2 = 5'd7;
        for (int i = 0; i < 11; i++) begin
            p_valid = tbl[i].pv; p_reg = tbl[i].pr; p_data = tbl[i].pd;
            ll_valid = tbl[i].lv; ll_reg = tbl[i].lr; ll_data = tbl[i].ld;
            rreg1 = tbl[i].rr1;
            tick($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.exp_regwrite", i), 32'(regwrite), 32'(tbl[i].e_rw));
            chk($sformatf("tbl%0d.exp_wreg", i),     32'(wreg),     32'(tbl[i].e_wreg));
            chk($sformatf("tbl%0d.exp_wdata", i),    wdata,         tbl[i].e_wdata);
            chk($sformatf("tbl%0d.exp_ll_ready", i), 32'(ll_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d.exp_pend1", i),    32'(pend1),    32'(tbl[i].e_p1));
        end
        idle();

        // fill and starve: pipeline holds the port while 5 results arrive
        k = 0; rreg1 = 5'd8; rreg2 = 5'd12;
        for (int c = 0; c < 12; c++) begin
            p_valid = 1'b1; p_reg = A'(1 + c); p_data = $urandom;
            ll_valid = (k < 5); ll_reg = A'(8 + k); ll_data = 32'h100 + k;
            xfer = ll_valid && mq.size() != QD;
            tick("fill");
            if (xfer) k++;
            chk("fill.ll_ready", 32'(ll_ready), 32'(k < 4));
            chk("fill.stall_at", 32'(stall_req), 32'(c >= 8));
        end
        // drain: 8..11 then 12, stall clears after the first pop
        p_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ll_valid = (k < 5); ll_reg = A'(8 + k); ll_data = 32'h100 + k;
            xfer = ll_valid && mq.size() != QD;
            tick("drain");
            if (xfer) k++;
            chk("drain.regwrite",  32'(regwrite),  1);
            chk("drain.wreg",      32'(wreg),      32'(8 + i));
            chk("drain.wdata",     wdata,          32'h100 + i);
            chk("drain.stall_req", 32'(stall_req), 0);
        end
        idle();
        tick("drain_done");
        chk("drain_done.regwrite", 32'(regwrite), 0);

        // reset mid-operation with entries 4 and 6 queued
        p_valid = 1'b1; p_reg = 5'd1; p_data = 32'h55;
        ll_valid = 1'b1; ll_reg = 5'd4; ll_data = 32'h44;
        tick("mid");
        p_reg = 5'd2; ll_reg = 5'd6; ll_data = 32'h66;
        tick("mid");
        rreg1 = 5'd4; rreg2 = 5'd6;
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("midrst.regwrite",  32'(regwrite),  0);
        chk("midrst.ll_ready",  32'(ll_ready),  1);
        chk("midrst.pend1",     32'(pend1),     0);
        chk("midrst.pend2",     32'(pend2),     0);
        chk("midrst.stall_req", 32'(stall_req), 0);
        idle();
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("postrst");
            chk("postrst.no_write", 32'(regwrite), 0);
        end

        // randomized traffic, small register range to provoke pend matches
        for (int c = 0; c < 600; c++) begin
            p_valid  = $urandom_range(0, 99) < 55;
            p_reg    = A'($urandom_range(0, 7));
            p_data   = $urandom;
            ll_valid = $urandom_range(0, 99) < 50;
            ll_reg   = A'($urandom_range(0, 7));
            ll_data  = $urandom;
            rreg1    = A'($urandom_range(0, 7));
            rreg2    = A'($urandom_range(0, 7));
            tick("rand");
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                model_reset();
                #1 check_all("rand_rst");
                #1 reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
